// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for a FIFO that is filled in bursts. The controller
// waits for the FIFO to report full, drains it word by word until it reports
// empty, and then waits for the next fill. Each word read is registered onto
// data_out with a one-cycle data_vld strobe and compared against an
// incrementing count pattern. Any mismatch raises a sticky error flag.
//
// Parameters
//   DW          FIFO data width in bits
//   CNT_W       width of the word and burst counters
//
// Ports
//   rd_clk      in   sole clock, all state updates on its rising edge
//   rst_n       in   asynchronous active-low reset
//   rd_rst_busy in   FIFO read-side reset in progress (forces IDLE)
//   full        in   FIFO full flag
//   empty       in   FIFO empty flag
//   dout        in   FIFO read data, valid the cycle after rd_en
//   rd_en       out  FIFO read enable (combinational)
//   data_out    out  registered copy of the last accepted read word
//   data_vld    out  one-cycle strobe per accepted word
//   word_cnt    out  words read in the current burst (saturating)
//   burst_cnt   out  completed bursts since reset (wrapping)
//   burst_done  out  high for the single DONE cycle at the end of a burst
//   err         out  sticky pattern-mismatch flag
//   state       out  current FSM state (IDLE=0, ARM=1, READ=2, DONE=3)
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             rd_rst_busy,
    input  logic             full,
    input  logic             empty,
    input  logic [DW-1:0]    dout,
    output logic             rd_en,
    output logic [DW-1:0]    data_out,
    output logic             data_vld,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] burst_cnt,
    output logic             burst_done,
    output logic             err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DAT_ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t          cur_state;
    state_t          nxt_state;
    logic            rd_pend;
    logic [DW-1:0]   exp_data;
    logic            enter_read;
    logic            enter_done;

    // State register.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic. A FIFO reset in progress overrides everything and
    // parks the controller in IDLE. ARM only starts a burst on a genuinely
    // full FIFO: full and empty together is a FIFO reset artefact, not data.
    always_comb begin
        nxt_state = cur_state;
        if (rd_rst_busy) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = ARM;
                ARM:     if (full && !empty) nxt_state = READ;
                READ:    if (empty) nxt_state = DONE;
                DONE:    nxt_state = ARM;
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign enter_read = (cur_state == ARM)  && (nxt_state == READ);
    assign enter_done = (cur_state == READ) && (nxt_state == DONE);

    // rd_en follows state directly so an asynchronous reset drops it at once.
    assign rd_en      = (cur_state == READ) && !empty && !rd_rst_busy;
    assign burst_done = (cur_state == DONE);
    assign state      = cur_state;

    // Word and burst counters. rd_en can never be high in ARM, so the clear
    // on READ entry and the per-word increment never collide.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            if (enter_read) begin
                word_cnt <= '0;
            end else if (rd_en && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + CNT_ONE;
            end
            if (enter_done) begin
                burst_cnt <= burst_cnt + CNT_ONE;
            end
        end
    end

    // Read data pipeline and pattern checker. rd_pend marks the cycle in
    // which the FIFO presents the requested word; it is deliberately not
    // cleared by rd_rst_busy so a read issued just before a FIFO reset
    // still completes. Only rst_n discards an in-flight word.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            data_vld <= 1'b0;
            data_out <= '0;
            exp_data <= '0;
            err      <= 1'b0;
        end else begin
            rd_pend  <= rd_en;
            data_vld <= rd_pend;
            if (rd_pend) begin
                data_out <= dout;
                exp_data <= exp_data + DAT_ONE;
                if (dout != exp_data) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Self-checking bench for fifo_rd_ctrl. A 16-deep FIFO environment answers the
// controller's rd_en. A reference model tracks the burst phase, a queue of
// outstanding reads with their delivery cycle, and the number of words
// delivered since reset (whose low byte is the expected pattern value).
// Every cycle all outputs are compared against the model, plus directed
// checks at the points of interest.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int CNT_W = 16;
    localparam int DEPTH = 16;

    logic             rd_clk;
    logic             rst_n;
    logic             rd_rst_busy;
    logic             full;
    logic             empty;
    logic [DW-1:0]    dout;
    logic             rd_en;
    logic [DW-1:0]    data_out;
    logic             data_vld;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_done;
    logic             err;
    logic [1:0]       state;

    fifo_rd_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .rd_clk      (rd_clk),
        .rst_n       (rst_n),
        .rd_rst_busy (rd_rst_busy),
        .full        (full),
        .empty       (empty),
        .dout        (dout),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_vld    (data_vld),
        .word_cnt    (word_cnt),
        .burst_cnt   (burst_cnt),
        .burst_done  (burst_done),
        .err         (err),
        .state       (state)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_vec = 0;
    int n_err = 0;

    // FIFO environment
    logic [7:0] env_q[$];
    int         env_popped;
    bit         artefact;

    // Reference model
    typedef struct {
        int         due;
        logic [7:0] w;
    } pend_t;

    logic [7:0] mq[$];
    pend_t      pend[$];
    int         cyc;
    int         m_phase;     // 0 idle, 1 waiting for fill, 2 draining, 3 burst end
    int         m_word;
    int         m_burst;
    bit         m_err;
    bit         m_vld;
    logic [7:0] m_data;
    int         delivered;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit model_rd_en();
        return (m_phase == 2) && !empty && !rd_rst_busy;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_phase   = 0;
        m_word    = 0;
        m_burst   = 0;
        m_err     = 1'b0;
        m_vld     = 1'b0;
        m_data    = 8'h00;
        delivered = 0;
    endtask

    task automatic update_flags();
        if (artefact) begin
            full  = 1'b1;
            empty = 1'b1;
        end else begin
            full  = (env_q.size() == DEPTH);
            empty = (env_q.size() == 0);
        end
    endtask

    task automatic clear_fifos();
        env_q.delete();
        mq.delete();
        update_flags();
    endtask

    // Effect of one rising edge, given the inputs seen before it.
    task automatic model_edge(input bit b, input bit f, input bit e, input bit mrd);
        pend_t p;
        logic [7:0] w;
        m_vld = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p      = pend.pop_front();
            m_vld  = 1'b1;
            m_data = p.w;
            if (p.w != 8'(delivered)) m_err = 1'b1;
            delivered++;
        end
        if (mrd) begin
            w = 8'h00;
            if (mq.size() > 0) w = mq.pop_front();
            pend.push_back('{due: cyc + 1, w: w});
            if (m_word < 65535) m_word++;
        end
        if (b) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (f && !e) begin m_phase = 2; m_word = 0; end
                2: if (e) begin m_phase = 3; m_burst = (m_burst + 1) % 65536; end
                default: m_phase = 1;
            endcase
        end
    endtask

    task automatic check_output();
        cmp("state",      32'(state),      32'(m_phase));
        cmp("rd_en",      32'(rd_en),      32'(model_rd_en()));
        cmp("data_vld",   32'(data_vld),   32'(m_vld));
        cmp("data_out",   32'(data_out),   32'(m_data));
        cmp("word_cnt",   32'(word_cnt),   32'(m_word));
        cmp("burst_cnt",  32'(burst_cnt),  32'(m_burst));
        cmp("burst_done", 32'(burst_done), 32'(m_phase == 3));
        cmp("err",        32'(err),        32'(m_err));
    endtask

    // One clock cycle: check at the falling edge, then advance environment
    // and model just after the rising edge.
    task automatic apply_stimulus();
        bit b, f, e, mrd, drd;
        @(negedge rd_clk);
        check_output();
        b   = rd_rst_busy;
        f   = full;
        e   = empty;
        drd = rd_en;
        mrd = model_rd_en();
        @(posedge rd_clk);
        #1;
        cyc++;
        if (drd && env_q.size() > 0) begin
            dout = env_q.pop_front();
            env_popped++;
        end
        if (rst_n) model_edge(b, f, e, mrd);
        update_flags();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic prefill(input int base, input int bad_idx, input bit rand_bad);
        logic [7:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'(base + i);
            if (i == bad_idx) w = 8'hAA;
            if (rand_bad && $urandom_range(0, 7) == 0) w = w ^ 8'h01;
            env_q.push_back(w);
            mq.push_back(w);
        end
        update_flags();
    endtask

    task automatic run_burst();
        bit saw_done;
        bit finished;
        saw_done = 1'b0;
        finished = 1'b0;
        for (int n = 0; n < 80 && !finished; n++) begin
            apply_stimulus();
            if (m_phase == 3) saw_done = 1'b1;
            if (m_phase == 1 && saw_done) finished = 1'b1;
        end
        n_vec++;
        assert (finished) else begin
            n_err++;
            $error("[TB] FAIL burst_timeout observed=%0d expected=1", finished);
        end
    endtask

    task automatic wait_reads(input int target);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            apply_stimulus();
            if (m_phase == 2 && m_word == target) hit = 1'b1;
        end
        n_vec++;
        assert (hit) else begin
            n_err++;
            $error("[TB] FAIL read_timeout observed=%0d expected=1", hit);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rd_rst_busy = 1'b1;
        dout        = 8'h00;
        artefact    = 1'b0;
        env_popped  = 0;
        cyc         = 0;
        model_reset();
        update_flags();
        #1;
        cmp("reset_state", 32'(state),     32'd0);
        cmp("reset_rd_en", 32'(rd_en),     32'd0);
        cmp("reset_vld",   32'(data_vld),  32'd0);
        cmp("reset_err",   32'(err),       32'd0);
        ticks(2);

        // Reset release with the FIFO still busy: controller must stay idle.
        rst_n = 1'b1;
        ticks(10);
        cmp("busy_idle_state", 32'(state), 32'd0);
        rd_rst_busy = 1'b0;
        apply_stimulus();
        cmp("arm_after_busy", 32'(state), 32'd1);

        // First burst 0..15.
        ticks($urandom_range(0, 4));
        prefill(env_popped, -1, 1'b0);
        run_burst();
        cmp("b1_word_cnt",  32'(word_cnt),  32'd16);
        cmp("b1_burst_cnt", 32'(burst_cnt), 32'd1);
        cmp("b1_err",       32'(err),       32'd0);
        cmp("b1_last_data", 32'(data_out),  32'h0F);

        // Second burst 16..31.
        ticks($urandom_range(0, 4));
        prefill(env_popped, -1, 1'b0);
        run_burst();
        cmp("b2_word_cnt",  32'(word_cnt),  32'd16);
        cmp("b2_burst_cnt", 32'(burst_cnt), 32'd2);
        cmp("b2_err",       32'(err),       32'd0);

        // full and empty together must not start a burst.
        artefact = 1'b1;
        update_flags();
        ticks(4);
        cmp("artefact_state", 32'(state), 32'd1);
        artefact = 1'b0;
        update_flags();

        // Third burst with word 5 corrupted: err sticks from then on.
        prefill(env_popped, 5, 1'b0);
        run_burst();
        cmp("b3_err",       32'(err),       32'd1);
        cmp("b3_burst_cnt", 32'(burst_cnt), 32'd3);
        prefill(env_popped, -1, 1'b0);
        run_burst();
        cmp("b4_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a burst after seven reads.
        ticks($urandom_range(0, 3));
        prefill(env_popped, -1, 1'b0);
        wait_reads(7);
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_mid_state", 32'(state),     32'd0);
        cmp("rst_mid_rd_en", 32'(rd_en),     32'd0);
        cmp("rst_mid_vld",   32'(data_vld),  32'd0);
        cmp("rst_mid_data",  32'(data_out),  32'd0);
        cmp("rst_mid_word",  32'(word_cnt),  32'd0);
        cmp("rst_mid_burst", 32'(burst_cnt), 32'd0);
        cmp("rst_mid_err",   32'(err),       32'd0);
        clear_fifos();
        env_popped = 0;
        ticks(2);
        cmp("rst_no_vld", 32'(data_vld), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Randomised bursts with occasional corrupted words.
        for (int k = 0; k < 3; k++) begin
            ticks($urandom_range(0, 5));
            prefill(env_popped, -1, 1'b1);
            run_burst();
        end

        // FIFO reset after four reads: the fourth word still arrives.
        prefill(env_popped, -1, 1'b0);
        wait_reads(4);
        rd_rst_busy = 1'b1;
        #1;
        cmp("busy_rd_en", 32'(rd_en), 32'd0);
        apply_stimulus();
        cmp("busy_state",    32'(state),    32'd0);
        cmp("busy_last_vld", 32'(data_vld), 32'd1);
        cmp("busy_word_cnt", 32'(word_cnt), 32'd4);
        clear_fifos();
        ticks(3);
        rd_rst_busy = 1'b0;
        ticks(2);

        // Clean burst continuing the pattern after the aborted one.
        prefill(env_popped, -1, 1'b0);
        run_burst();
        cmp("final_word_cnt", 32'(word_cnt), 32'd16);
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
